nco_phase_to_amplitude: RTL and testbench

NCO_PHASE_TO_AMPLITUDE -- requirements
Module: nco_phase_to_amplitude

---
 rtl/nco_phase_to_amplitude_pkg.sv | 48 ++++
 rtl/nco_phase_to_amplitude_rom.sv | 40 ++++
 rtl/nco_phase_to_amplitude.sv | 100 ++++++++++
 tb/tb_nco_phase_to_amplitude.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/nco_phase_to_amplitude_pkg.sv
// ============================================================================
// nco_phase_to_amplitude_pkg : shared NCO constants and quarter-sine table math
// Rev 1.0
// ============================================================================
`default_nettype none

package nco_phase_to_amplitude_pkg;

  localparam logic        NCO_RST_ACTIVE = 1'b1;
  localparam int unsigned NCO_PHASE_W    = 32;
  localparam int unsigned NCO_ADDR_W     = 8;
  localparam int unsigned NCO_AMP_W      = 16;

  localparam int unsigned SINE_FRAC_W = 60;
  // pi scaled by 2^60, taken from the hex expansion 3.243F6A8885A308D3...
  localparam logic [127:0] SINE_PI_FP = 128'h3243F6A8885A308D;

  // round((2^(amp_w-1)-1) * sin(pi/2 * (idx+0.5) / 2^addr_w)) in integer-only
  // fixed point, so the table is a pure elaboration-time constant.
  function automatic logic [127:0] quarter_sine_entry(
    input int unsigned idx,
    input int unsigned addr_w,
    input int unsigned amp_w
  );
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc;
    logic [127:0] amp_max;
    x    = (SINE_PI_FP * 128'(2 * idx + 1)) >> (addr_w + 2);
    x2   = (x * x) >> SINE_FRAC_W;
    term = x;
    acc  = x;
    for (int n = 3; n <= 27; n += 2) begin
      term = ((term * x2) >> SINE_FRAC_W) / 128'(n * (n - 1));
      if ((((n - 1) / 2) % 2) == 1) begin
        acc = acc - term;
      end else begin
        acc = acc + term;
      end
    end
    amp_max = (128'd1 << (amp_w - 1)) - 128'd1;
    return (acc * amp_max + (128'd1 << (SINE_FRAC_W - 1))) >> SINE_FRAC_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nco_phase_to_amplitude_rom.sv
// ============================================================================
// nco_quarter_sine_rom : quarter-wave sine ROM, synchronous read, 1-cycle latency
// Rev 1.0
// ============================================================================
`default_nettype none

module nco_quarter_sine_rom
  import nco_phase_to_amplitude_pkg::*;
#(
  parameter int unsigned ADDR_W = NCO_ADDR_W,
  parameter int unsigned DATA_W = NCO_AMP_W - 1
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rom_table [DEPTH];
  logic [DATA_W-1:0] data_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [127:0] C_VAL = quarter_sine_entry(gi, ADDR_W, DATA_W + 1);
    assign rom_table[gi] = C_VAL[DATA_W-1:0];
  end

  // No reset: contents are constant and the read register is qualified downstream.
  always_ff @(posedge clk) begin
    if (en_i) begin
      data_q <= rom_table[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/nco_phase_to_amplitude.sv
// ============================================================================
// nco_phase_to_amplitude : 3-stage phase-to-sine converter using a quarter-wave ROM
// Rev 1.0
// ============================================================================
`default_nettype none

module nco_phase_to_amplitude
  import nco_phase_to_amplitude_pkg::*;
#(
  parameter int unsigned PHASE_W = NCO_PHASE_W,
  parameter int unsigned ADDR_W  = NCO_ADDR_W,
  parameter int unsigned AMP_W   = NCO_AMP_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [PHASE_W-1:0] lut_index_i,
  input  logic                      valid_i,
  output logic signed [AMP_W-1:0]   sample_o,
  output logic                      valid_o
);

  logic [1:0]              quad;
  logic [ADDR_W-1:0]       offset;
  logic [ADDR_W-1:0]       addr_d;
  logic [ADDR_W-1:0]       addr_q;
  logic                    sign1_q;
  logic                    valid1_q;
  logic                    sign2_q;
  logic                    valid2_q;
  logic                    valid3_q;
  logic [AMP_W-2:0]        rom_data;
  logic signed [AMP_W-1:0] mag;
  logic signed [AMP_W-1:0] sample_d;
  logic signed [AMP_W-1:0] sample_q;

  assign quad   = lut_index_i[PHASE_W-1 -: 2];
  assign offset = lut_index_i[PHASE_W-3 -: ADDR_W];
  // Odd quadrants run the quarter wave backwards.
  assign addr_d = quad[0] ? ~offset : offset;

  if (PHASE_W > ADDR_W + 2) begin : g_trunc
    logic unused_lsbs;
    assign unused_lsbs = ^lut_index_i[PHASE_W-3-ADDR_W:0];
  end

  always_ff @(posedge clk) begin
    if (rst == NCO_RST_ACTIVE) begin
      valid1_q <= 1'b0;
    end else begin
      valid1_q <= valid_i;
    end
    if (valid_i) begin
      addr_q  <= addr_d;
      sign1_q <= quad[1];
    end
  end

  nco_quarter_sine_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (AMP_W - 1)
  ) u_rom (
    .clk    (clk),
    .en_i   (valid1_q),
    .addr_i (addr_q),
    .data_o (rom_data)
  );

  always_ff @(posedge clk) begin
    if (rst == NCO_RST_ACTIVE) begin
      valid2_q <= 1'b0;
    end else begin
      valid2_q <= valid1_q;
    end
    if (valid1_q) begin
      sign2_q <= sign1_q;
    end
  end

  // Zero-extended magnitude never reaches -2^(AMP_W-1), so negation cannot overflow.
  assign mag      = $signed({1'b0, rom_data});
  assign sample_d = sign2_q ? -mag : mag;

  always_ff @(posedge clk) begin
    if (rst == NCO_RST_ACTIVE) begin
      valid3_q <= 1'b0;
      sample_q <= '0;
    end else begin
      valid3_q <= valid2_q;
      if (valid2_q) begin
        sample_q <= sample_d;
      end
    end
  end

  assign sample_o = sample_q;
  assign valid_o  = valid3_q;

endmodule

`default_nettype wire

// File: tb/tb_nco_phase_to_amplitude.sv
// ============================================================================
// tb_nco_phase_to_amplitude : directed self-checking bench for the sine converter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nco_phase_to_amplitude;

  logic               clk;
  logic               rst;
  logic [31:0]        lut_index_i;
  logic               valid_i;
  logic signed [15:0] sample_o;
  logic               valid_o;

  int n_total;
  int n_bad;
  int held;
  int pk_max;
  int pk_min;

  typedef struct {
    bit    v;
    int    s;
    string tag;
  } exp_t;

  exp_t q_exp[$];

  nco_phase_to_amplitude dut (
    .clk         (clk),
    .rst         (rst),
    .lut_index_i (lut_index_i),
    .valid_i     (valid_i),
    .sample_o    (sample_o),
    .valid_o     (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // First-quadrant reference amplitude for ROM address a.
  function automatic int g0(input int a);
    real x;
    x = 32767.0 * $sin(3.141592653589793 * (real'(a) + 0.5) / 512.0);
    return $rtoi(x + 0.5);
  endfunction

  function automatic int exp_sample(input logic [31:0] idx);
    logic [1:0] q;
    int         a;
    int         m;
    q = idx[31:30];
    a = int'(idx[29:22]);
    m = q[0] ? g0(255 - a) : g0(a);
    return q[1] ? -m : m;
  endfunction

  function automatic exp_t idle_entry();
    exp_t e;
    e.v   = 1'b0;
    e.s   = 0;
    e.tag = "flushed";
    return e;
  endfunction

  // Drive one input cycle; after the edge, check the output of the input from 3 cycles earlier.
  task automatic drive(input bit v, input logic [31:0] idx, input int exp_s, input string tag);
    exp_t e;
    lut_index_i = idx;
    valid_i     = v;
    e.v   = v;
    e.s   = exp_s;
    e.tag = tag;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    if (q_exp.size() >= 3) begin
      e = q_exp.pop_front();
      if (e.v) begin
        check_eq({e.tag, ":valid_o"}, int'(valid_o), 1);
        check_eq({e.tag, ":sample_o"}, int'(sample_o), e.s);
        held = e.s;
      end else begin
        check_eq({e.tag, ":valid_o"}, int'(valid_o), 0);
        check_eq({e.tag, ":held_sample_o"}, int'(sample_o), held);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    rst         = 1'b1;
    valid_i     = 1'b0;
    lut_index_i = '0;
    @(posedge clk);
    #1;
    check_eq({tag, ":valid_o"}, int'(valid_o), 0);
    check_eq({tag, ":sample_o"}, int'(sample_o), 0);
    rst  = 1'b0;
    held = 0;
    q_exp.delete();
    q_exp.push_back(idle_entry());
    q_exp.push_back(idle_entry());
  endtask

  initial begin
    logic [31:0] acc;
    n_total     = 0;
    n_bad       = 0;
    held        = 0;
    rst         = 1'b1;
    valid_i     = 1'b0;
    lut_index_i = '0;
    do_reset("por");

    drive(1'b1, 32'h0000_0000, 101,    "q0_a0");
    drive(1'b1, 32'h4000_0000, 32767,  "q1_a0");
    drive(1'b1, 32'h8000_0000, -101,   "q2_a0");
    drive(1'b1, 32'hC000_0000, -32767, "q3_a0");
    drive(1'b1, 32'h3FC0_0000, 32767,  "q0_a255");
    drive(1'b1, 32'h7FC0_0000, 101,    "q1_a255");
    drive(1'b1, 32'h003F_FFFF, 101,    "trunc_lsbs");
    drive(1'b1, 32'hFFFF_FFFF, -101,   "wrap_top");
    drive(1'b1, 32'h0000_0000, 101,    "wrap_zero");

    drive(1'b1, 32'h4000_0000, 32767, "tog1a");
    drive(1'b0, 32'h8000_0000, 0,     "tog0a");
    drive(1'b1, 32'h0000_0000, 101,   "tog1b");
    drive(1'b0, 32'hC000_0000, 0,     "tog0b");

    for (int i = 0; i < 1024; i++) begin
      drive(1'b1, 32'(i) << 22, exp_sample(32'(i) << 22), $sformatf("ramp%0d", i));
    end

    drive(1'b1, 32'h4000_0000, 32767,  "pre_rst1");
    drive(1'b1, 32'h8000_0000, -101,   "pre_rst2");
    drive(1'b1, 32'hC000_0000, -32767, "pre_rst3");
    do_reset("mid_rst");
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h4000_0000, 0, $sformatf("post_rst_idle%0d", i));
    end
    drive(1'b1, 32'h8000_0000, -101, "post_rst_first");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0000_0000, 0, $sformatf("post_rst_tail%0d", i));
    end

    // Phase accumulator stepping 0x01000000, running past one wrap.
    acc    = 32'h0;
    pk_max = -100000;
    pk_min = 100000;
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, acc, exp_sample(acc), $sformatf("nco%0d", n));
      if (valid_o) begin
        if (int'(sample_o) > pk_max) pk_max = int'(sample_o);
        if (int'(sample_o) < pk_min) pk_min = int'(sample_o);
      end
      acc = acc + 32'h0100_0000;
    end
    check_eq("nco_peak_max", pk_max, 32767);
    check_eq("nco_peak_min", pk_min, -32767);

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0000_0000, 0, "drain");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
